adc_bcd_scaler: RTL and testbench
=================================

# adc_bcd_scaler

Multi-channel successor to the single-channel voltage display converter. It periodically samples `CHANNELS` 16-bit ADC result words, scales each to a fixed-point decimal quantity (microvolts by default), and converts each value to `NUM_DIGITS` BCD digits. Conversion uses a sequential shift-add-3 engine shared across channels, not a combinational divide chain. It sits between the XADC/DRP reader and the seven-segment multiplexer, and adds manual trigger, hold, saturation and overrun reporting.

## Interface
- `CHANNELS`, 4: number of ADC channels packed on `data`.
- `DATA_W`, 16: width of each channel word; the ADC code is left-justified in it.
- `ADC_BITS`, 12: significant code bits; `code = word >> (DATA_W-ADC_BITS)`.
- `NUM_DIGITS`, 7: BCD digits per channel.
- `SCALE_MUL`, 250000: scale multiplier.
- `SCALE_SHIFT`, 10: right shift applied after the multiply.
- `SAT_CODE`, 4093: codes >= this value saturate.
- `SAMPLE_PERIOD`, 20000000: clock cycles between automatic frames; 0 disables auto mode.
- `CLK100MHZ`  in  1: system clock; all logic is on the rising edge.
- `CPU_RESETN`  in  1: asynchronous, active-low reset.
- `data`  in  CHANNELS*DATA_W: channel words; channel k is `[k*DATA_W +: DATA_W]`.
- `trig`  in  1: single-cycle manual frame request.
- `hold`  in  1: while high, automatic and manual frames are suppressed and digit outputs freeze.
- `digits`  out  CHANNELS*NUM_DIGITS*4: BCD digits; channel k digit d is at `[(k*NUM_DIGITS+d)*4 +: 4]`; d=0 is the least significant digit.
- `sat`  out  CHANNELS: per-channel saturation flag from the last frame.
- `busy`  out  1: high while a frame is in progress.
- `frame_done`  out  1: one-cycle pulse when all channels have been written.
- `overrun`  out  1: sticky; set when a frame request is dropped because the block is busy; cleared only by reset.

## Operation
- Derived widths:
  - `BIN_W = clog2(10^NUM_DIGITS)`, which is 24 for the defaults.
  - The product register is `ADC_BITS + clog2(SCALE_MUL+1)` bits wide.
- Period counter: counts 0..SAMPLE_PERIOD-1, then wraps. `tick` is asserted on the cycle the count equals SAMPLE_PERIOD-1. The counter keeps running while `hold` is high.
- Frame request: `req = (tick | trig) & ~hold`.
  - Accepted only in IDLE.
  - A request arriving in any other state is dropped and sets `overrun`.
- FSM states:
  - IDLE: on `req`, go to CAPTURE.
  - CAPTURE: latch the whole `data` bus into a snapshot register; set ch=0; go to LOAD.
  - LOAD:
    - Extract `code` for channel ch.
    - If `code >= SAT_CODE`: set the scratch value to 10^(NUM_DIGITS-1), set `sat[ch]`, and go directly to SHIFT.
    - Otherwise clear `sat[ch]` and go to MULT.
  - MULT: `bin = (code*SCALE_MUL) >> SCALE_SHIFT`, truncated to BIN_W; go to SHIFT.
  - SHIFT: BIN_W iterations of double-dabble. In each iteration, add 3 to every BCD nibble >= 5, then shift left 1 with the binary MSB entering. Then go to STORE.
  - STORE: write the BCD result to channel ch's slice of `digits`. If ch==CHANNELS-1, go to DONE; otherwise ch++ and go to LOAD.
  - DONE: pulse `frame_done`; go to IDLE.
- `digits` for a channel change only in STORE, so the other channels stay stable mid-frame.
- Parameter legality: the maximum unsaturated scaled value must be < 10^NUM_DIGITS. This is a simulation-time assertion only.

## Timing
- Reset values: `digits`=0, `sat`=0, `busy`=0, `frame_done`=0, `overrun`=0, counter=0, FSM=IDLE.
- `busy` is high from the cycle after the request is accepted (CAPTURE) through DONE inclusive.
- Per-channel cost:
  - Normal: LOAD + MULT + BIN_W + STORE = BIN_W+3 cycles, i.e. 27 for the defaults.
  - Saturated: BIN_W+2 cycles.
- Frame latency: request at cycle t gives `frame_done` at t + 2 + sum(per-channel) + 1. For 4 unsaturated channels that is t+111.
- Simultaneous `tick` and `trig` in IDLE: one frame starts; `overrun` is not set.
- `trig` together with `hold`: ignored, and `overrun` is not set.
- `hold` rising mid-frame: the frame completes normally. `hold` gates only new requests.
- Reset asserted mid-frame: everything returns to its reset values immediately; partial results are discarded.

## Test plan
- Single code values with `trig`:
  - Channel 0 = 16'h0010 (code 1) -> 0000244, sat=0.
  - 16'h8000 (code 2048) -> 0500000.
  - 16'h0000 -> 0000000.
- Saturation: 16'hFFD0 (code 4093) and 16'hFFF0 (4095) -> 1000000, sat=1. 16'hFFC0 (4092) -> 0999023, sat=0.
- Four channels = {16'h0010, 16'h8000, 16'h4000, 16'hFFF0} with one `trig`:
  - Digits in order: 0000244, 0500000, 0250000, 1000000.
  - `frame_done` exactly 1 cycle wide, at request+2+3*27+26+1.
- Auto mode with SAMPLE_PERIOD=200:
  - Frames start every 200 cycles.
  - Changing `data` mid-frame does not alter that frame's results.
- `trig` pulsed while `busy` -> frame unaffected, `overrun`=1 and stays 1. `hold`=1 with `trig` -> no frame, `digits` unchanged, `overrun` unchanged.
- `CPU_RESETN` low during SHIFT of channel 2 -> all outputs 0 within the same cycle. After release, a new `trig` yields a correct full frame.

Source files
------------

// File: rtl/adc_bcd_scaler.sv
// Multi-channel ADC word scaler: snapshots CHANNELS left-justified codes, scales each
// to a fixed-point decimal value and converts it to BCD with one shared double-dabble engine.
module adc_bcd_scaler #(
    parameter int CHANNELS      = 4,
    parameter int DATA_W        = 16,
    parameter int ADC_BITS      = 12,
    parameter int NUM_DIGITS    = 7,
    parameter int SCALE_MUL     = 250000,
    parameter int SCALE_SHIFT   = 10,
    parameter int SAT_CODE      = 4093,
    parameter int SAMPLE_PERIOD = 20000000
) (
    input  logic                               CLK100MHZ,
    input  logic                               CPU_RESETN,
    input  logic [CHANNELS*DATA_W-1:0]         data,
    input  logic                               trig,
    input  logic                               hold,
    output logic [CHANNELS*NUM_DIGITS*4-1:0]   digits,
    output logic [CHANNELS-1:0]                sat,
    output logic                               busy,
    output logic                               frame_done,
    output logic                               overrun
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] DEC_RANGE = pow10(NUM_DIGITS);
    localparam int BIN_W   = $clog2(DEC_RANGE);
    localparam int BCD_W   = NUM_DIGITS * 4;
    localparam int PROD_W  = ADC_BITS + $clog2(SCALE_MUL + 1);
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int ITER_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int CNT_W   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    localparam logic [BIN_W-1:0]  SAT_BIN   = BIN_W'(pow10(NUM_DIGITS - 1));
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(BIN_W - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = (SAMPLE_PERIOD > 0) ? CNT_W'(SAMPLE_PERIOD - 1) : '0;

    localparam logic [63:0] CODE_TOP   = (64'd1 << ADC_BITS) - 64'd1;
    localparam logic [63:0] MAX_CODE   = ((64'(SAT_CODE) - 64'd1) < CODE_TOP) ? (64'(SAT_CODE) - 64'd1) : CODE_TOP;
    localparam logic [63:0] MAX_SCALED = (MAX_CODE * 64'(SCALE_MUL)) >> SCALE_SHIFT;

    // The largest unsaturated result must fit in NUM_DIGITS decimal digits.
    if (MAX_SCALED >= DEC_RANGE) begin : g_range_check
        $error("adc_bcd_scaler: scaled range does not fit NUM_DIGITS");
    end

    function automatic logic [BIN_W-1:0] scale(input logic [ADC_BITS-1:0] c);
        logic [PROD_W-1:0] p;
        p = PROD_W'(c) * PROD_W'(SCALE_MUL);
        return BIN_W'(p >> SCALE_SHIFT);
    endfunction

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int d = 0; d < NUM_DIGITS; d++)
            if (v[d*4 +: 4] >= 4'd5) r[d*4 +: 4] = v[d*4 +: 4] + 4'd3;
        return r;
    endfunction

    typedef enum logic [2:0] {IDLE, CAPTURE, LOAD, MULT, SHIFT, STORE, DONE} state_t;

    state_t                      state, state_nxt;
    logic [CH_W-1:0]             ch;
    logic [CNT_W-1:0]            cnt;
    logic [CHANNELS*DATA_W-1:0]  snap;
    logic [BIN_W-1:0]            bin;
    logic [BCD_W-1:0]            bcd;
    logic [ITER_W-1:0]           iter;
    logic [ADC_BITS-1:0]         code;
    logic                        tick, req, saturated, last_ch;

    assign tick      = (SAMPLE_PERIOD != 0) && (cnt == CNT_LAST);
    assign req       = (tick | trig) & ~hold;
    assign code      = snap[int'(ch)*DATA_W + (DATA_W - ADC_BITS) +: ADC_BITS];
    assign saturated = 32'(code) >= 32'(SAT_CODE);
    assign last_ch   = (ch == CH_LAST);
    assign busy      = (state != IDLE);

    // Period counter free-runs, hold only gates the request it produces.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (SAMPLE_PERIOD > 1) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = CAPTURE;
            CAPTURE: state_nxt = LOAD;
            LOAD:    state_nxt = saturated ? SHIFT : MULT;
            MULT:    state_nxt = SHIFT;
            SHIFT:   if (iter == ITER_LAST) state_nxt = STORE;
            STORE:   state_nxt = last_ch ? DONE : LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state      <= IDLE;
            ch         <= '0;
            digits     <= '0;
            sat        <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= (state == DONE);
            if (req && (state != IDLE)) overrun <= 1'b1;
            case (state)
                CAPTURE: ch <= '0;
                LOAD:    sat[ch] <= saturated;
                STORE: begin
                    digits[int'(ch)*BCD_W +: BCD_W] <= bcd;
                    if (!last_ch) ch <= ch + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Scratch datapath: LOAD presets the saturation value, MULT overwrites it when in range.
    always_ff @(posedge CLK100MHZ) begin
        case (state)
            CAPTURE: snap <= data;
            LOAD: begin
                bin  <= SAT_BIN;
                bcd  <= '0;
                iter <= '0;
            end
            MULT: bin <= scale(code);
            SHIFT: begin
                {bcd, bin} <= {add3(bcd), bin} << 1;
                iter       <= iter + 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_adc_bcd_scaler.sv
// Directed bench for adc_bcd_scaler: one instance with auto mode off, one with a 200-cycle period.
module tb_adc_bcd_scaler;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   data, data_a;
    logic          trig, hold, trig_a, hold_a;
    logic [111:0]  digits, digits_a;
    logic [3:0]    sat, sat_a;
    logic          busy, frame_done, overrun;
    logic          busy_a, frame_done_a, overrun_a;
    int            n_checks = 0;
    int            n_errors = 0;
    int unsigned   cyc_count = 0;

    localparam logic [15:0] WORDS [6] = '{16'h0010, 16'h8000, 16'h0000, 16'hFFD0, 16'hFFF0, 16'hFFC0};
    localparam logic [27:0] EXP1  [6] = '{28'h0000244, 28'h0500000, 28'h0000000,
                                          28'h1000000, 28'h1000000, 28'h0999023};
    localparam logic        SAT1  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    localparam logic [63:0]  VEC4 = {16'hFFF0, 16'h4000, 16'h8000, 16'h0010};
    localparam logic [111:0] EXP4 = {28'h1000000, 28'h0250000, 28'h0500000, 28'h0000244};
    localparam logic [63:0]  VECO = {16'h0010, 16'h0000, 16'hFFF0, 16'h8000};
    localparam logic [111:0] EXPO = {28'h0000244, 28'h0000000, 28'h1000000, 28'h0500000};
    localparam logic [63:0]  VECA = {16'h0000, 16'hFFC0, 16'h0010, 16'h8000};
    localparam logic [111:0] EXPA = {28'h0000000, 28'h0999023, 28'h0000244, 28'h0500000};

    always #5 clk = ~clk;
    always @(posedge clk) cyc_count <= cyc_count + 1;

    adc_bcd_scaler #(.SAMPLE_PERIOD(0)) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .data      (data),
        .trig      (trig),
        .hold      (hold),
        .digits    (digits),
        .sat       (sat),
        .busy      (busy),
        .frame_done(frame_done),
        .overrun   (overrun)
    );

    adc_bcd_scaler #(.SAMPLE_PERIOD(200)) dut_auto (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .data      (data_a),
        .trig      (trig_a),
        .hold      (hold_a),
        .digits    (digits_a),
        .sat       (sat_a),
        .busy      (busy_a),
        .frame_done(frame_done_a),
        .overrun   (overrun_a)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [27:0] dig(input logic [111:0] d, input int k);
        return d[k*28 +: 28];
    endfunction

    // Pulses trig for one cycle, optionally re-pulses trig / raises hold mid-frame,
    // and returns the cycle count from the trig cycle to the frame_done pulse.
    task automatic run_frame(input logic [63:0] vec, input int extra_trig, input int hold_at,
                             output int lat);
        data = vec;
        check_eq("idle_busy", busy, 1'b0);
        trig = 1'b1;
        step();
        trig = 1'b0;
        lat  = 1;
        check_eq("busy_capture", busy, 1'b1);
        while (!frame_done && lat < 400) begin
            trig = (lat == extra_trig);
            if (lat == hold_at) hold = 1'b1;
            step();
            lat++;
        end
        trig = 1'b0;
        hold = 1'b0;
        check_eq("frame_seen", frame_done, 1'b1);
        step();
        check_eq("done_width", frame_done, 1'b0);
    endtask

    initial begin : main
        int          lat;
        int          n;
        logic        saw;
        int unsigned t1;

        rst_n  = 1'b0;
        data   = '0;
        data_a = VECA;
        trig   = 1'b0;
        hold   = 1'b0;
        trig_a = 1'b0;
        hold_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_digits", digits, '0);
        check_eq("rst_sat", sat, '0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", frame_done, 1'b0);
        check_eq("rst_overrun", overrun, 1'b0);
        #2 rst_n = 1'b1;
        step();
        step();

        for (int i = 0; i < 6; i++) begin
            run_frame({48'h0, WORDS[i]}, 0, 0, lat);
            check_eq("single_digits", dig(digits, 0), EXP1[i]);
            check_eq("single_sat", sat, {3'b000, SAT1[i]});
            check_eq("single_latency", lat, SAT1[i] ? 110 : 111);
        end

        run_frame(VEC4, 0, 0, lat);
        check_eq("quad_digits", digits, EXP4);
        check_eq("quad_sat", sat, 4'b1000);
        check_eq("quad_latency", lat, 110);
        check_eq("quad_busy_after", busy, 1'b0);

        hold = 1'b1;
        data = {4{16'h8000}};
        trig = 1'b1;
        step();
        trig = 1'b0;
        saw  = 1'b0;
        repeat (150) begin
            if (busy || frame_done) saw = 1'b1;
            step();
        end
        hold = 1'b0;
        check_eq("hold_no_frame", saw, 1'b0);
        check_eq("hold_digits", digits, EXP4);
        check_eq("hold_overrun", overrun, 1'b0);

        run_frame(VECO, 30, 40, lat);
        check_eq("ovr_digits", digits, EXPO);
        check_eq("ovr_sat", sat, 4'b0010);
        check_eq("ovr_latency", lat, 110);
        check_eq("ovr_flag", overrun, 1'b1);
        run_frame(VEC4, 0, 0, lat);
        check_eq("ovr_sticky", overrun, 1'b1);
        check_eq("ovr_next_digits", digits, EXP4);

        n = 0;
        while (busy_a && n < 500) begin step(); n++; end
        while (!busy_a && n < 500) begin step(); n++; end
        check_eq("auto_start", busy_a, 1'b1);
        t1 = cyc_count;
        repeat (5) step();
        data_a = {4{16'h4000}};
        n = 0;
        while (!frame_done_a && n < 300) begin step(); n++; end
        check_eq("auto_done", frame_done_a, 1'b1);
        check_eq("auto_snapshot", digits_a, EXPA);
        check_eq("auto_sat", sat_a, 4'b0000);
        while (cyc_count < t1 + 199) step();
        check_eq("auto_idle_before_tick", busy_a, 1'b0);
        trig_a = 1'b1;
        step();
        trig_a = 1'b0;
        check_eq("auto_period", busy_a, 1'b1);
        n = 0;
        while (!frame_done_a && n < 300) begin step(); n++; end
        check_eq("auto_done2", frame_done_a, 1'b1);
        check_eq("auto_new_data", digits_a, {4{28'h0250000}});
        check_eq("auto_tick_trig_overrun", overrun_a, 1'b0);

        data = VEC4;
        trig = 1'b1;
        step();
        trig = 1'b0;
        repeat (64) step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_digits", digits, '0);
        check_eq("midrst_sat", sat, '0);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_overrun", overrun, 1'b0);
        check_eq("midrst_done", frame_done, 1'b0);
        check_eq("midrst_auto_digits", digits_a, '0);
        step();
        #2 rst_n = 1'b1;
        step();
        run_frame(VEC4, 0, 0, lat);
        check_eq("post_rst_digits", digits, EXP4);
        check_eq("post_rst_sat", sat, 4'b1000);
        check_eq("post_rst_latency", lat, 110);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
